// File: rtl/dist_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dist_seq_ctrl
//
// Sequencer for the edge-count distribution datapath. It counts samples that
// the frame buffer accepts, kicks the distribution generator once the
// population is full (and again after every FRAME_SIZE fresh samples), waits
// for the generator to finish, then reads back NUM_BINS histogram bins and
// streams them downstream over a valid/ready handshake.
//
// Optional feature macro: TIMEOUT_EN
//   Defined   -> a watchdog bounds the CALC wait to TIMEOUT cycles and raises
//                the sticky timeout_err when it expires.
//   Undefined -> no watchdog is built, CALC waits forever, timeout_err = 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   enable       gates the start of new calculations (a running one finishes)
//   sample_stb   one-cycle pulse per sample accepted by the frame buffer
//   gen_start    one-cycle start pulse to the generator
//   gen_done     generator completion (level or pulse)
//   bin_rd       one-cycle bin read request to the generator
//   bin_idx      index of the bin being read / presented
//   bin_in       bin value returned RD_LAT cycles after bin_rd
//   m_valid      output bin valid
//   m_ready      downstream ready
//   m_data       output bin value
//   m_last       marks the final bin of a run
//   busy         high whenever the sequencer is not idle
//   frame_drop   one-cycle pulse when a trigger is lost to overrun
//   timeout_err  sticky generator watchdog error
// -----------------------------------------------------------------------------
module dist_seq_ctrl #(
    parameter int POPSIZE    = 100,
    parameter int FRAME_SIZE = 20,
    parameter int NUM_BINS   = 6,
    parameter int BIN_W      = $clog2(POPSIZE),
    parameter int RD_LAT     = 1,
    parameter int TIMEOUT    = 4096,
    localparam int IDX_W     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sample_stb,
    output logic             gen_start,
    input  logic             gen_done,
    output logic             bin_rd,
    output logic [IDX_W-1:0] bin_idx,
    input  logic [BIN_W-1:0] bin_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BIN_W-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             frame_drop,
    output logic             timeout_err
);

    localparam int FILL_W = $clog2(POPSIZE + 1);
    localparam int NEW_W  = $clog2(FRAME_SIZE + 1);
    localparam int LAT_W  = $clog2(RD_LAT + 1);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(POPSIZE);
    localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(POPSIZE - 1);
    localparam logic [NEW_W-1:0]  NEW_MAX  = NEW_W'(FRAME_SIZE);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_BINS - 1);

    // Reject parameter sets the read pipeline and watchdog cannot honour.
    if (RD_LAT < 1 || RD_LAT > 4 || TIMEOUT < 1) begin : g_param_check
        $error("dist_seq_ctrl: RD_LAT must be 1..4 and TIMEOUT at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CALC,
        S_RD,
        S_RWAIT,
        S_OUT
    } state_t;

    state_t            state;
    logic [FILL_W-1:0] fill_cnt;
    logic [NEW_W-1:0]  new_cnt;
    logic              primed;
    logic              ran_once;
    logic [LAT_W-1:0]  lat_cnt;
    logic              new_full;
    logic              trigger;

`ifdef TIMEOUT_EN
    localparam int                CALC_W    = $clog2(TIMEOUT + 1);
    localparam logic [CALC_W-1:0] CALC_LAST = CALC_W'(TIMEOUT - 1);
    logic [CALC_W-1:0] calc_cnt;
`endif

    // The very first run only needs a primed population; every later run
    // needs a full frame of fresh samples.
    always_comb begin
        new_full = (new_cnt == NEW_MAX);
        trigger  = enable && primed && (!ran_once || new_full);
    end

    // Sample bookkeeping runs in every state. new_cnt is only consumed when a
    // trigger is accepted in IDLE, so an overrun keeps it saturated and yields
    // exactly one trigger once the sequencer comes back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt   <= '0;
            new_cnt    <= '0;
            primed     <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= sample_stb && new_full && (state != S_IDLE);

            if (sample_stb && (fill_cnt != FILL_MAX)) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
                if (fill_cnt == FILL_PRE) begin
                    primed <= 1'b1;
                end
            end

            if ((state == S_IDLE) && trigger) begin
                new_cnt <= sample_stb ? NEW_W'(1) : '0;
            end else if (sample_stb && !new_full) begin
                new_cnt <= new_cnt + NEW_W'(1);
            end
        end
    end

    // Main sequencer. All handshake outputs are registered alongside the
    // state so each is valid exactly while its state is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ran_once  <= 1'b0;
            bin_idx   <= '0;
            lat_cnt   <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            gen_start <= 1'b0;
            bin_rd    <= 1'b0;
            busy      <= 1'b0;
`ifdef TIMEOUT_EN
            calc_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            gen_start <= 1'b0;
            bin_rd    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state     <= S_START;
                        gen_start <= 1'b1;
                        busy      <= 1'b1;
                        ran_once  <= 1'b1;
                    end
                end

                // gen_done is deliberately not looked at here: a level left
                // high from the previous run must not end this one.
                S_START: begin
                    state <= S_CALC;
`ifdef TIMEOUT_EN
                    calc_cnt <= '0;
`endif
                end

                S_CALC: begin
                    if (gen_done) begin
                        state   <= S_RD;
                        bin_idx <= '0;
                        bin_rd  <= 1'b1;
                    end
`ifdef TIMEOUT_EN
                    else if (calc_cnt == CALC_LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        m_valid     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        calc_cnt <= calc_cnt + CALC_W'(1);
                    end
`endif
                end

                S_RD: begin
                    state   <= S_RWAIT;
                    lat_cnt <= '0;
                end

                // The generator answers RD_LAT cycles after bin_rd; capture
                // on the last wait cycle.
                S_RWAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state   <= S_OUT;
                        m_data  <= bin_in;
                        m_valid <= 1'b1;
                        m_last  <= (bin_idx == IDX_LAST);
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                S_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (m_last) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_RD;
                            bin_idx <= bin_idx + IDX_W'(1);
                            bin_rd  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dist_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dist_seq_ctrl
//
// Scoreboard bench for dist_seq_ctrl. Directed sample sequences drive the
// sequencer; every run that is expected to stream bins pushes its bins into a
// queue, and a negedge monitor pops and compares on each handshake. A small
// generator model answers bin_rd exactly RD_LAT cycles later and drives a
// poison value at every other time.
// -----------------------------------------------------------------------------
module tb_dist_seq_ctrl;

    localparam int POPSIZE    = 100;
    localparam int FRAME_SIZE = 20;
    localparam int NUM_BINS   = 6;
    localparam int BIN_W      = 7;
    localparam int RD_LAT     = 3;
    localparam int TIMEOUT    = 64;
    localparam int IDX_W      = 3;
    localparam logic [BIN_W-1:0] POISON = 7'h7F;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             sample_stb;
    logic             gen_start;
    logic             gen_done;
    logic             bin_rd;
    logic [IDX_W-1:0] bin_idx;
    logic [BIN_W-1:0] bin_in;
    logic             m_valid;
    logic             m_ready;
    logic [BIN_W-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             frame_drop;
    logic             timeout_err;

    typedef struct packed {
        logic [BIN_W-1:0] data;
        logic             last;
        logic [IDX_W-1:0] idx;
    } bin_t;

    bin_t exp_q[$];
    bin_t mon_exp;
    int   checks    = 0;
    int   failures  = 0;
    int   start_cnt = 0;
    int   drop_cnt  = 0;
    int   rd_cnt    = 0;
    int   run_base  = 0;
    int   rd_age    = -1;
    int   rd_idx    = 0;
    int   snap;

    logic             hold_pending = 1'b0;
    logic [BIN_W-1:0] held_data;
    logic             held_last;
    logic [IDX_W-1:0] held_idx;

    dist_seq_ctrl #(
        .POPSIZE   (POPSIZE),
        .FRAME_SIZE(FRAME_SIZE),
        .NUM_BINS  (NUM_BINS),
        .BIN_W     (BIN_W),
        .RD_LAT    (RD_LAT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sample_stb (sample_stb),
        .gen_start  (gen_start),
        .gen_done   (gen_done),
        .bin_rd     (bin_rd),
        .bin_idx    (bin_idx),
        .bin_in     (bin_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .frame_drop (frame_drop),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BIN_W-1:0] binValue(input int base, input int i);
        return BIN_W'(base + 3 * i);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sample strobe per two cycles.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            sample_stb = 1'b1;
            tick(1);
            sample_stb = 1'b0;
            tick(1);
        end
    endtask

    task automatic pulseDone();
        gen_done = 1'b1;
        tick(1);
        gen_done = 1'b0;
        tick(1);
    endtask

    task automatic pushRun(input int base);
        bin_t e;
        for (int i = 0; i < NUM_BINS; i++) begin
            e.data = binValue(base, i);
            e.last = (i == NUM_BINS - 1);
            e.idx  = IDX_W'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic waitValid(input int budget, input string name);
        int n = 0;
        while (!m_valid && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, {31'd0, m_valid}, 32'd1);
    endtask

    task automatic waitStart(input int old, input int budget, input string name);
        int n = 0;
        while (start_cnt == old && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, start_cnt, old + 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gen_start"}, {31'd0, gen_start}, 32'd0);
        checkOutput({tag, "_bin_rd"}, {31'd0, bin_rd}, 32'd0);
        checkOutput({tag, "_bin_idx"}, {29'd0, bin_idx}, 32'd0);
        checkOutput({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        checkOutput({tag, "_m_data"}, {25'd0, m_data}, 32'd0);
        checkOutput({tag, "_m_last"}, {31'd0, m_last}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_frame_drop"}, {31'd0, frame_drop}, 32'd0);
        checkOutput({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    // Generator model: bin_in carries the requested bin only in the single
    // cycle RD_LAT cycles after bin_rd, poison otherwise.
    always @(posedge clk) begin
        #1;
        bin_in = POISON;
        if (rd_age >= 0) begin
            rd_age++;
            if (rd_age == RD_LAT) begin
                bin_in = binValue(run_base, rd_idx);
                rd_age = -1;
            end
        end
        if (bin_rd) begin
            rd_age = 0;
            rd_idx = int'(bin_idx);
        end
    end

    // Monitor: event counters, hold-stability during stalls, scoreboard pops.
    always @(negedge clk) begin
        if (gen_start)  start_cnt++;
        if (frame_drop) drop_cnt++;
        if (bin_rd)     rd_cnt++;
        if (m_valid) checkOutput("no_rd_while_valid", {31'd0, bin_rd}, 32'd0);
        if (hold_pending && !rst) begin
            checkOutput("hold_valid", {31'd0, m_valid}, 32'd1);
            checkOutput("hold_data", {25'd0, m_data}, {25'd0, held_data});
            checkOutput("hold_last", {31'd0, m_last}, {31'd0, held_last});
            checkOutput("hold_idx", {29'd0, bin_idx}, {29'd0, held_idx});
        end
        hold_pending = m_valid && !m_ready && !rst;
        held_data    = m_data;
        held_last    = m_last;
        held_idx     = bin_idx;
        if (m_valid && m_ready && !rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_bin: got data %0d idx %0d expected no transfer",
                         m_data, bin_idx);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("bin_data", {25'd0, m_data}, {25'd0, mon_exp.data});
                checkOutput("bin_last", {31'd0, m_last}, {31'd0, mon_exp.last});
                checkOutput("bin_idx", {29'd0, bin_idx}, {29'd0, mon_exp.idx});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        sample_stb = 1'b0;
        gen_done   = 1'b0;
        m_ready    = 1'b1;
        bin_in     = POISON;
        tick(3);
        checkAllZero("reset");
        rst = 1'b0;
        tick(2);

        // Initial fill: 99 samples are not enough, the 100th starts 2 cycles on.
        $display("[TB] initial fill");
        applyStimulus(99);
        tick(5);
        checkOutput("fill99_no_start", start_cnt, 0);
        checkOutput("fill99_idle", {31'd0, busy}, 32'd0);
        run_base = 0;
        pushRun(0);
        sample_stb = 1'b1;
        tick(1);
        sample_stb = 1'b0;
        checkOutput("start_not_early", {31'd0, gen_start}, 32'd0);
        tick(1);
        checkOutput("start_after_2", {31'd0, gen_start}, 32'd1);
        checkOutput("busy_with_start", {31'd0, busy}, 32'd1);
        tick(1);
        checkOutput("start_one_cycle", {31'd0, gen_start}, 32'd0);
        tick(50);
        pulseDone();
        waitIdle(200, "run0_complete");
        checkOutput("run0_all_bins", exp_q.size(), 0);
        checkOutput("run0_start_count", start_cnt, 1);

        // Sliding frame plus overrun during a long CALC.
        $display("[TB] sliding frame and overrun");
        run_base = 1;
        applyStimulus(19);
        tick(5);
        checkOutput("frame19_no_start", start_cnt, 1);
        pushRun(1);
        sample_stb = 1'b1;
        tick(1);
        sample_stb = 1'b0;
        tick(1);
        gen_done = 1'b1;
        tick(1);
        gen_done = 1'b0;
        checkOutput("frame20_start", start_cnt, 2);
        snap = rd_cnt;
        applyStimulus(45);
        checkOutput("done_in_start_ignored", rd_cnt, snap);
        checkOutput("calc_still_busy", {31'd0, busy}, 32'd1);
        checkOutput("drop_pulses", drop_cnt, 25);
        pulseDone();
        waitStart(2, 200, "overrun_restart");
        checkOutput("run1_all_bins", exp_q.size(), 0);
        checkOutput("drop_pulses_final", drop_cnt, 25);

        // Restarted run streamed with backpressure on bin 2.
        $display("[TB] backpressure");
        run_base = 2;
        pushRun(2);
        m_ready = 1'b0;
        snap = rd_cnt;
        tick(10);
        pulseDone();
        for (int b = 0; b < NUM_BINS; b++) begin
            waitValid(50, "bp_bin_valid");
            if (b == 2) tick(10);
            m_ready = 1'b1;
            tick(1);
            m_ready = 1'b0;
        end
        waitIdle(50, "run2_complete");
        checkOutput("bp_read_count", rd_cnt - snap, NUM_BINS);
        checkOutput("run2_all_bins", exp_q.size(), 0);
        m_ready = 1'b1;

        // enable low blocks the trigger; raising it starts immediately.
        $display("[TB] enable gating");
        enable   = 1'b0;
        run_base = 3;
        applyStimulus(20);
        tick(5);
        checkOutput("disabled_idle", {31'd0, busy}, 32'd0);
        checkOutput("disabled_no_start", start_cnt, 3);
        pushRun(3);
        enable = 1'b1;
        tick(1);
        checkOutput("reenable_start", {31'd0, gen_start}, 32'd1);
        tick(20);
        pulseDone();
        waitIdle(200, "run3_complete");
        checkOutput("run3_all_bins", exp_q.size(), 0);

        // Reset while a bin is stalled in OUT, then a full refill is needed.
        $display("[TB] reset mid-output");
        m_ready  = 1'b0;
        run_base = 4;
        applyStimulus(20);
        tick(5);
        pulseDone();
        waitValid(50, "rst_run_valid");
        rst = 1'b1;
        #1;
        checkAllZero("rst_mid_out");
        tick(2);
        rst     = 1'b0;
        m_ready = 1'b1;
        snap    = start_cnt;
        applyStimulus(99);
        tick(3);
        checkOutput("refill99_no_start", start_cnt, snap);
        pushRun(4);
        applyStimulus(1);
        checkOutput("refill100_start", {31'd0, gen_start}, 32'd1);
        tick(30);
        pulseDone();
        waitIdle(200, "run4_complete");
        checkOutput("run4_all_bins", exp_q.size(), 0);

`ifdef TIMEOUT_EN
        // Generator never answers: watchdog fires, then a normal run follows.
        $display("[TB] watchdog");
        snap = rd_cnt;
        applyStimulus(20);
        begin
            int n = 0;
            while (!timeout_err && n < 200) begin
                tick(1);
                n++;
            end
        end
        checkOutput("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        checkOutput("timeout_idle", {31'd0, busy}, 32'd0);
        checkOutput("timeout_no_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("timeout_no_reads", rd_cnt, snap);
        run_base = 5;
        pushRun(5);
        applyStimulus(20);
        tick(10);
        pulseDone();
        waitIdle(200, "run5_complete");
        checkOutput("run5_all_bins", exp_q.size(), 0);
        checkOutput("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
`else
        checkOutput("timeout_err_tied", {31'd0, timeout_err}, 32'd0);
`endif

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
